// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and defaults for the ram_req_ctrl front-end and its clear sequencer.
package ram_req_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RSP     = 2'd3
    } state_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset sweep counter: walks addresses 0..DEPTH-1 once with we high, then holds done.
module ram_clear_seq
    import ram_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we,
    output logic                  done
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            // Last word written on this edge; the counter wrap is harmless since busy drops
            if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign addr = cnt;
    assign we   = busy;

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read data (read-first on same-address write).
module sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Valid/ready request front-end for sync_ram with a registered read-response channel.
// Optional post-reset zero-fill sweep is built when RAM_REQ_CTRL_CLEAR_EN is defined.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);

    state_t state;

`ifdef RAM_REQ_CTRL_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  clr_done;

    ram_clear_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_seq (
        .clk (clk),
        .rst (rst),
        .addr(clr_addr),
        .we  (clr_we),
        .done(clr_done)
    );

    assign init_done = clr_done;
`else
    localparam state_t RESET_STATE = ST_IDLE;

    logic init_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign init_done = init_done_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_STATE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
`ifdef RAM_REQ_CTRL_CLEAR_EN
                ST_CLEAR: begin
                    if (&clr_addr) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    if (req_valid && !req_we) begin
                        state <= ST_RD_WAIT;
                    end
                end
                // RAM output register holds the word addressed at the accept edge
                ST_RD_WAIT: begin
                    rsp_rdata <= ram_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr;
        ram_din   = req_wdata;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                ram_we    = req_valid & req_we;
            end
`ifdef RAM_REQ_CTRL_CLEAR_EN
            ST_CLEAR: begin
                ram_we   = clr_we;
                ram_addr = clr_addr;
                ram_din  = '0;
            end
`endif
            default: ;
        endcase
    end

endmodule
